// File: rtl/idex_pipeline_reg.sv
// rtl/idex_pipeline_reg.sv - ID/EX pipeline latch with load-use bubble, flush and sticky halt; optional counters under IDEX_PERF_EN
module idex_pipeline_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 12
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [31:0]       instr_in,
  input  logic [DATA_W-1:0] pc4_in,
  input  logic [DATA_W-1:0] rdat1_in,
  input  logic [DATA_W-1:0] rdat2_in,
  input  logic [DATA_W-1:0] imm_in,
  input  logic [4:0]        wsel_in,
  input  logic              uses_rt_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic              valid_out,
  output logic [31:0]       instr_out,
  output logic [DATA_W-1:0] pc4_out,
  output logic [DATA_W-1:0] rdat1_out,
  output logic [DATA_W-1:0] rdat2_out,
  output logic [DATA_W-1:0] imm_out,
  output logic [4:0]        wsel_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              luhaz,
  output logic              halt_out,
  output logic [31:0]       bubble_cnt,
  output logic [31:0]       flush_cnt
);

  logic advance;
  logic load;
  logic take_bubble;
  logic hit_rs;
  logic hit_rt;

  // Load-use hazard: held load writes a register the ID instruction reads; $zero never matches
  always_comb begin
    hit_rs = (wsel_out == instr_in[25:21]);
    hit_rt = uses_rt_in & (wsel_out == instr_in[20:16]);
    luhaz  = valid_out & ctrl_out[1] & (wsel_out != 5'd0) & valid_in & (hit_rs | hit_rt);
  end

  // Halt is simply the latched halt bit; bubbles carry ctrl=0, so flush releases it for free
  assign halt_out    = ctrl_out[3];
  assign advance     = ihit & ~stall & ~halt_out;
  assign load        = flush | advance;
  assign take_bubble = flush | luhaz | ~valid_in;

  // Pipeline latch: flush or advance loads either a bubble or the ID fields, otherwise hold
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_out <= 1'b0;
      instr_out <= '0;
      pc4_out   <= '0;
      rdat1_out <= '0;
      rdat2_out <= '0;
      imm_out   <= '0;
      wsel_out  <= '0;
      ctrl_out  <= '0;
    end else if (load) begin
      if (take_bubble) begin
        valid_out <= 1'b0;
        instr_out <= '0;
        pc4_out   <= '0;
        rdat1_out <= '0;
        rdat2_out <= '0;
        imm_out   <= '0;
        wsel_out  <= '0;
        ctrl_out  <= '0;
      end else begin
        valid_out <= 1'b1;
        instr_out <= instr_in;
        pc4_out   <= pc4_in;
        rdat1_out <= rdat1_in;
        rdat2_out <= rdat2_in;
        imm_out   <= imm_in;
        wsel_out  <= wsel_in;
        ctrl_out  <= ctrl_in;
      end
    end
  end

`ifdef IDEX_PERF_EN
  logic [31:0] bubble_q;
  logic [31:0] flush_q;

  // Saturating event counters: load-use bubbles (flush has priority) and flushes
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bubble_q <= '0;
      flush_q  <= '0;
    end else begin
      if (~flush & advance & luhaz & (bubble_q != 32'hFFFF_FFFF))
        bubble_q <= bubble_q + 32'd1;
      if (flush & (flush_q != 32'hFFFF_FFFF))
        flush_q <= flush_q + 32'd1;
    end
  end

  assign bubble_cnt = bubble_q;
  assign flush_cnt  = flush_q;
`else
  assign bubble_cnt = 32'd0;
  assign flush_cnt  = 32'd0;
`endif

endmodule
